// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the MIPS core datapath.
package mips_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_RADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SLT = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Forwarding compare and 3:1 operand mux for a single EX source register.
module fwd_select import mips_pkg::*; #(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W
) (
    input  logic [RADDR_W-1:0] src_reg,
    input  logic [DATA_W-1:0]  rf_data,
    input  logic               m_reg_write,
    input  logic [RADDR_W-1:0] m_write_reg,
    input  logic [DATA_W-1:0]  m_result,
    input  logic               w_reg_write,
    input  logic [RADDR_W-1:0] w_write_reg,
    input  logic [DATA_W-1:0]  w_result,
    output logic [DATA_W-1:0]  operand
);

    fwd_sel_e sel;

    // MEM is the younger producer, so it wins over WB; r0 is hard-wired zero.
    always_comb begin
        sel = FWD_RF;
        if (m_reg_write && (m_write_reg != '0) && (m_write_reg == src_reg))
            sel = FWD_MEM;
        else if (w_reg_write && (w_write_reg != '0) && (w_write_reg == src_reg))
            sel = FWD_WB;
    end

    always_comb begin
        case (sel)
            FWD_MEM: operand = m_result;
            FWD_WB:  operand = w_result;
            default: operand = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection and MEM/WB operand forwarding.
module id_ex_operand_stage import mips_pkg::*; #(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  ID_RD1,
    input  logic [DATA_W-1:0]  ID_RD2,
    input  logic [DATA_W-1:0]  ID_SignImm,
    input  logic [RADDR_W-1:0] ID_Rs,
    input  logic [RADDR_W-1:0] ID_Rt,
    input  logic [RADDR_W-1:0] ID_Rd,
    input  logic               ID_RegWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_MemWrite,
    input  logic               ID_ALUSrc,
    input  logic               ID_RegDst,
    input  logic [2:0]         ID_ALUControl,
    input  logic               FlushE,
    input  logic               M_RegWrite,
    input  logic [RADDR_W-1:0] M_WriteReg,
    input  logic [DATA_W-1:0]  M_ALUResult,
    input  logic               W_RegWrite,
    input  logic [RADDR_W-1:0] W_WriteReg,
    input  logic [DATA_W-1:0]  W_Result,
    output logic [DATA_W-1:0]  SrcA,
    output logic [DATA_W-1:0]  SrcB,
    output logic [2:0]         ALUControl,
    output logic [DATA_W-1:0]  E_WriteData,
    output logic [RADDR_W-1:0] E_WriteReg,
    output logic               E_RegWrite,
    output logic               E_MemtoReg,
    output logic               E_MemWrite,
    output logic               E_Valid,
    output logic               StallD
);

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               memto_reg;
        logic               mem_write;
        logic               alu_src;
        logic               reg_dst;
        logic [2:0]         alu_control;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  rd1;
        logic [DATA_W-1:0]  rd2;
        logic [DATA_W-1:0]  sign_imm;
    } ex_reg_t;

    ex_reg_t ex;
    ex_reg_t id_bundle;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    always_comb begin
        id_bundle             = '0;
        id_bundle.valid       = 1'b1;
        id_bundle.reg_write   = ID_RegWrite;
        id_bundle.memto_reg   = ID_MemtoReg;
        id_bundle.mem_write   = ID_MemWrite;
        id_bundle.alu_src     = ID_ALUSrc;
        id_bundle.reg_dst     = ID_RegDst;
        id_bundle.alu_control = ID_ALUControl;
        id_bundle.rs          = ID_Rs;
        id_bundle.rt          = ID_Rt;
        id_bundle.rd          = ID_Rd;
        id_bundle.rd1         = ID_RD1;
        id_bundle.rd2         = ID_RD2;
        id_bundle.sign_imm    = ID_SignImm;
    end

    assign E_WriteReg = ex.reg_dst ? ex.rd : ex.rt;

    // A load in EX whose result is needed by the decode instruction cannot be forwarded in time.
    assign StallD = ex.valid && ex.memto_reg && ex.reg_write && (E_WriteReg != '0) &&
                    ((E_WriteReg == ID_Rs) || (E_WriteReg == ID_Rt));

    // Flush and load-use both clear the whole register, so their overlap is still a single bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ex <= '0;
        else if (FlushE || StallD)
            ex <= '0;
        else
            ex <= id_bundle;
    end

    fwd_select #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
        .src_reg     (ex.rs),
        .rf_data     (ex.rd1),
        .m_reg_write (M_RegWrite),
        .m_write_reg (M_WriteReg),
        .m_result    (M_ALUResult),
        .w_reg_write (W_RegWrite),
        .w_write_reg (W_WriteReg),
        .w_result    (W_Result),
        .operand     (fwd_rs)
    );

    fwd_select #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
        .src_reg     (ex.rt),
        .rf_data     (ex.rd2),
        .m_reg_write (M_RegWrite),
        .m_write_reg (M_WriteReg),
        .m_result    (M_ALUResult),
        .w_reg_write (W_RegWrite),
        .w_write_reg (W_WriteReg),
        .w_result    (W_Result),
        .operand     (fwd_rt)
    );

    assign SrcA        = fwd_rs;
    assign SrcB        = ex.alu_src ? ex.sign_imm : fwd_rt;
    assign E_WriteData = fwd_rt;
    assign ALUControl  = ex.alu_control;
    assign E_RegWrite  = ex.reg_write;
    assign E_MemtoReg  = ex.memto_reg;
    assign E_MemWrite  = ex.mem_write;
    assign E_Valid     = ex.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed hazard/forwarding cases plus random traffic.
module tb_id_ex_operand_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ID_RD1, ID_RD2, ID_SignImm;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
    logic        ID_RegWrite, ID_MemtoReg, ID_MemWrite, ID_ALUSrc, ID_RegDst;
    logic [2:0]  ID_ALUControl;
    logic        FlushE;
    logic        M_RegWrite, W_RegWrite;
    logic [4:0]  M_WriteReg, W_WriteReg;
    logic [31:0] M_ALUResult, W_Result;
    logic [31:0] SrcA, SrcB, E_WriteData;
    logic [2:0]  ALUControl;
    logic [4:0]  E_WriteReg;
    logic        E_RegWrite, E_MemtoReg, E_MemWrite, E_Valid, StallD;

    int errors = 0;
    int checks = 0;

    // The instruction the model believes sits in EX.
    typedef struct {
        bit          valid;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        bit          rw, m2r, mw, alusrc, regdst;
        logic [2:0]  alu;
    } ex_t;
    ex_t ex;

    id_ex_operand_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_SignImm(ID_SignImm),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_MemWrite(ID_MemWrite),
        .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_ALUControl(ID_ALUControl),
        .FlushE(FlushE),
        .M_RegWrite(M_RegWrite), .M_WriteReg(M_WriteReg), .M_ALUResult(M_ALUResult),
        .W_RegWrite(W_RegWrite), .W_WriteReg(W_WriteReg), .W_Result(W_Result),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .E_WriteData(E_WriteData),
        .E_WriteReg(E_WriteReg), .E_RegWrite(E_RegWrite), .E_MemtoReg(E_MemtoReg),
        .E_MemWrite(E_MemWrite), .E_Valid(E_Valid), .StallD(StallD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
        if (r != 5'd0 && M_RegWrite && M_WriteReg == r) return M_ALUResult;
        if (r != 5'd0 && W_RegWrite && W_WriteReg == r) return W_Result;
        return rf;
    endfunction

    function automatic logic [4:0] dest();
        return ex.regdst ? ex.rd : ex.rt;
    endfunction

    function automatic bit exp_stall();
        return ex.valid && ex.m2r && ex.rw && dest() != 5'd0 &&
               (dest() == ID_Rs || dest() == ID_Rt);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] a, b;
        a = operand(ex.rs, ex.rd1);
        b = operand(ex.rt, ex.rd2);
        check({tag, ".SrcA"},        SrcA, a);
        check({tag, ".SrcB"},        SrcB, ex.alusrc ? ex.imm : b);
        check({tag, ".E_WriteData"}, E_WriteData, b);
        check({tag, ".ALUControl"},  32'(ALUControl), 32'(ex.alu));
        check({tag, ".E_WriteReg"},  32'(E_WriteReg), 32'(dest()));
        check({tag, ".E_RegWrite"},  32'(E_RegWrite), 32'(ex.rw));
        check({tag, ".E_MemtoReg"},  32'(E_MemtoReg), 32'(ex.m2r));
        check({tag, ".E_MemWrite"},  32'(E_MemWrite), 32'(ex.mw));
        check({tag, ".E_Valid"},     32'(E_Valid), 32'(ex.valid));
        check({tag, ".StallD"},      32'(StallD), 32'(exp_stall()));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (reset || FlushE || exp_stall()) begin
            ex = '{default: '0};
        end else begin
            ex.valid = 1'b1;      ex.rd1 = ID_RD1;       ex.rd2 = ID_RD2;
            ex.imm = ID_SignImm;  ex.rs = ID_Rs;         ex.rt = ID_Rt;
            ex.rd = ID_Rd;        ex.rw = ID_RegWrite;   ex.m2r = ID_MemtoReg;
            ex.mw = ID_MemWrite;  ex.alusrc = ID_ALUSrc; ex.regdst = ID_RegDst;
            ex.alu = ID_ALUControl;
        end
        #1;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                            input logic rw, input logic m2r, input logic mw, input logic alusrc,
                            input logic regdst, input logic [2:0] alu);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_RD1 = rd1; ID_RD2 = rd2; ID_SignImm = imm;
        ID_RegWrite = rw; ID_MemtoReg = m2r; ID_MemWrite = mw; ID_ALUSrc = alusrc;
        ID_RegDst = regdst; ID_ALUControl = alu;
    endtask

    task automatic rand_inputs();
        drive_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom(), $urandom(), $urandom(),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 3'($urandom));
        FlushE      = ($urandom_range(0, 7) == 0);
        M_RegWrite  = 1'($urandom);
        M_WriteReg  = 5'($urandom_range(0, 7));
        M_ALUResult = $urandom();
        W_RegWrite  = 1'($urandom);
        W_WriteReg  = 5'($urandom_range(0, 7));
        W_Result    = $urandom();
    endtask

    initial begin
        ex = '{default: '0};
        drive_id(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND);
        FlushE = 1'b0;
        M_RegWrite = 1'b0; M_WriteReg = 5'd0; M_ALUResult = 32'h0;
        W_RegWrite = 1'b0; W_WriteReg = 5'd0; W_Result = 32'h0;
        reset = 1'b1;
        #2;
        check_all("reset");
        check("reset.SrcA_zero", SrcA, 32'h0);
        clock_edge();
        reset = 1'b0;

        // Reset mid-cycle clears a loaded instruction before the next edge
        drive_id(5'd3, 5'd4, 5'd8, 32'h5, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
        clock_edge();
        check("t1.loaded_RegWrite", 32'(E_RegWrite), 32'd1);
        check("t1.loaded_SrcA", SrcA, 32'h5);
        reset = 1'b1;
        ex = '{default: '0};
        #1;
        check("t1.async_RegWrite", 32'(E_RegWrite), 32'd0);
        check("t1.async_Valid", 32'(E_Valid), 32'd0);
        check("t1.async_SrcA", SrcA, 32'h0);
        check("t1.async_StallD", 32'(StallD), 32'd0);
        check_all("t1");
        clock_edge();
        reset = 1'b0;

        // MEM forward to rs
        drive_id(5'd3, 5'd4, 5'd8, 32'h5, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
        clock_edge();
        M_RegWrite = 1'b1; M_WriteReg = 5'd3; M_ALUResult = 32'h10;
        #1;
        check("t2.SrcA_mem", SrcA, 32'h10);
        check_all("t2");

        // MEM beats WB for rt
        drive_id(5'd1, 5'd7, 5'd9, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB);
        clock_edge();
        M_RegWrite = 1'b1; M_WriteReg = 5'd7; M_ALUResult = 32'hAA;
        W_RegWrite = 1'b1; W_WriteReg = 5'd7; W_Result = 32'hBB;
        #1;
        check("t3.SrcB_mem", SrcB, 32'hAA);
        check("t3.WriteData_mem", E_WriteData, 32'hAA);
        check_all("t3");
        M_RegWrite = 1'b0;
        #1;
        check("t3.SrcB_wb", SrcB, 32'hBB);
        check_all("t3b");

        // r0 never forwarded
        drive_id(5'd0, 5'd2, 5'd9, 32'h0, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);
        clock_edge();
        M_RegWrite = 1'b1; M_WriteReg = 5'd0; M_ALUResult = 32'h99;
        W_RegWrite = 1'b1; W_WriteReg = 5'd0; W_Result = 32'h77;
        #1;
        check("t4.SrcA_r0", SrcA, 32'h0);
        check_all("t4");

        // Load-use: lw r5 in EX, decode reads r5
        M_RegWrite = 1'b0; W_RegWrite = 1'b0;
        drive_id(5'd1, 5'd5, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
        clock_edge();
        drive_id(5'd5, 5'd2, 5'd6, 32'h3, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
        #1;
        check("t5.StallD", 32'(StallD), 32'd1);
        check_all("t5.stall");
        clock_edge();
        check("t5.bubble_Valid", 32'(E_Valid), 32'd0);
        check("t5.bubble_RegWrite", 32'(E_RegWrite), 32'd0);
        check("t5.bubble_StallD", 32'(StallD), 32'd0);
        check_all("t5.bubble");
        clock_edge();
        W_RegWrite = 1'b1; W_WriteReg = 5'd5; W_Result = 32'h55;
        #1;
        check("t5.SrcA_wb", SrcA, 32'h55);
        check("t5.reload_Valid", 32'(E_Valid), 32'd1);
        M_RegWrite = 1'b1; M_WriteReg = 5'd5; M_ALUResult = 32'h66;
        #1;
        check("t5.SrcA_mem", SrcA, 32'h66);
        check_all("t5.reload");

        // Immediate operand with rt forwarded from WB into store data
        M_RegWrite = 1'b0;
        W_RegWrite = 1'b1; W_WriteReg = 5'd9; W_Result = 32'h1234;
        drive_id(5'd2, 5'd9, 5'd10, 32'h0, 32'h8, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
        clock_edge();
        check("t6.SrcB_imm", SrcB, 32'hFFFFFFFC);
        check("t6.WriteData_wb", E_WriteData, 32'h1234);
        check_all("t6");

        // FlushE coinciding with load-use gives a single bubble
        W_RegWrite = 1'b0;
        drive_id(5'd0, 5'd6, 5'd0, 32'h0, 32'h0, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
        clock_edge();
        drive_id(5'd6, 5'd1, 5'd3, 32'h7, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT);
        FlushE = 1'b1;
        #1;
        check("t6.flush_StallD", 32'(StallD), 32'd1);
        clock_edge();
        FlushE = 1'b0;
        #1;
        check("t6.flush_bubble_Valid", 32'(E_Valid), 32'd0);
        check("t6.flush_StallD_clear", 32'(StallD), 32'd0);
        clock_edge();
        check("t6.flush_reload_Valid", 32'(E_Valid), 32'd1);
        check_all("t6.flush");

        // Reset during a stall drops StallD immediately
        drive_id(5'd0, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
        clock_edge();
        drive_id(5'd4, 5'd4, 5'd2, 32'h1, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND);
        #1;
        check("t7.StallD", 32'(StallD), 32'd1);
        reset = 1'b1;
        ex = '{default: '0};
        #1;
        check("t7.reset_StallD", 32'(StallD), 32'd0);
        check("t7.reset_Valid", 32'(E_Valid), 32'd0);
        clock_edge();
        reset = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                ex = '{default: '0};
            end else begin
                reset = 1'b0;
            end
            #1;
            check_all("rand");
            clock_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
